uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Param SYSCLK_RATE, default 100000000, system clock frequency in Hz.
REQ-002 Param BAUD_RATE, default 9600, line bit rate.
REQ-003 Param DATA_BITS, default 8, data bits per frame, sent LSB first.
REQ-004 Param PARITY_BIT, default 1, 1 = even parity bit present, 0 = none.
REQ-005 Param STOP_BITS, default 2, stop bits expected (1 or 2).
REQ-006 Param FIFO_DEPTH, default 8, receive FIFO entries, power of 2.
REQ-007 SysClk  in  1  single clock; all logic on posedge.
REQ-008 Rst  in  1  reset, synchronous and active-high.
REQ-009 Rx  in  1  asynchronous serial line, idle high.
REQ-010 Read_Done  in  1  pop strobe for the FIFO.
REQ-011 Data_Out  out  DATA_BITS  registered popped word.
REQ-012 Data_Rdy  out  1  one-cycle pulse per frame written to FIFO.
REQ-013 Rx_Error  out  3  [0] parity, [1] framing, [2] break; per last frame.
REQ-014 FIFO_Empty / FIFO_Full / FIFO_Overflow  out  1 each  FIFO status.
REQ-015 RTS  out  1  1 = ready to accept frames.

Function
REQ-016 CLKS_PER_BIT SHALL be SYSCLK_RATE/BAUD_RATE (integer divide); HALF = CLKS_PER_BIT/2.
REQ-017 Rx SHALL pass a 2-flop synchronizer, both flops reset to 1, before any use.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE: synced Rx low -> START, bit counter cleared.
REQ-020 START: at HALF clocks, Rx low -> DATA; Rx high -> IDLE (false start), no output change.
REQ-021 DATA: sample every CLKS_PER_BIT at bit centre; after DATA_BITS samples -> PARITY if PARITY_BIT, else STOP.
REQ-022 PARITY: one centre sample; parity error = XOR(data, sample) != 0.
REQ-023 STOP: sample STOP_BITS centres; any low sample sets framing error; after last centre -> IDLE (no wait for full stop bit).
REQ-024 Break: data all zero AND framing error; break frames SHALL NOT be written to FIFO.
REQ-025 Rx_Error SHALL be updated on the frame-completion cycle and held until the next completed frame.
REQ-026 Non-break frames, including parity and framing errors, SHALL be pushed 1 cycle after the last stop-bit sample; Data_Rdy pulses that cycle.
REQ-027 Pop: Read_Done high at an edge with FIFO non-empty -> Data_Out <= head, read pointer advances; Data_Out holds otherwise.
REQ-028 Pop while empty SHALL be ignored.
REQ-029 Push and pop in the same cycle when full SHALL both succeed, with no overflow.
REQ-030 Push and pop in the same cycle when empty: push succeeds, pop ignored.
REQ-031 Push while full (no pop) SHALL drop the word and set FIFO_Overflow, sticky until the next successful pop or reset.
REQ-032 FIFO_Empty and FIFO_Full SHALL be registered and reflect occupancy after the current edge.

Reset
REQ-033 Rst SHALL force IDLE at any point, including mid-frame, and empty the FIFO.
REQ-034 On Rst: Data_Out=0, Data_Rdy=0, Rx_Error=0, FIFO_Empty=1, FIFO_Full=0, FIFO_Overflow=0, RTS=1.

Configuration
REQ-035 Macro UART_RX_RTS_EN defined: RTS = 0 when occupancy >= FIFO_DEPTH-1, otherwise 1; registered.
REQ-036 Macro UART_RX_RTS_EN undefined: RTS tied 1; no occupancy comparator.

Structure
REQ-037 Package UARTPkg SHALL hold the FSM state enum, the Rx_Error bit-index constants and a CLKS_PER_BIT function.
REQ-038 Sub-module uart_rx_fifo SHALL hold storage, pointers, occupancy count and status flags; uart_receiver holds synchronizer, FSM and counters.

Verification (SYSCLK_RATE=1600000, BAUD_RATE=100000 -> 16 clk/bit)
REQ-039 Frame 0xA5, parity 0, 2 stop bits -> Data_Rdy pulse; Rx_Error=000; Read_Done pop -> Data_Out=0xA5, FIFO_Empty=1.
REQ-040 Frame 0x3C with parity 1 -> word pushed, Rx_Error=001; frame 0x55 with stop bit 1 low -> Rx_Error=010.
REQ-041 Rx low for 240 clocks (break) -> Rx_Error=110, no push; 4-clock low glitch -> no Data_Rdy.
REQ-042 Nine frames 0x01..0x09, no pops -> FIFO_Full after 8, 0x09 dropped, FIFO_Overflow=1; eight pops return 0x01..0x08; RTS=0 from the 7th word (UART_RX_RTS_EN).
REQ-043 Rst asserted mid-DATA of a frame -> IDLE; all outputs at reset values; next clean frame 0x7E received correctly.
REQ-044 FIFO full, push and Read_Done in the same cycle -> no overflow, FIFO_Full stays 1, order preserved.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// UARTPkg: shared types and helpers for the UART receive path.
// Holds the receiver FSM state encoding, the Rx_Error bit positions
// and the bit-period calculation used to size the sampling counters.
package UARTPkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Bit positions inside Rx_Error
    localparam int ERR_PARITY  = 0;
    localparam int ERR_FRAMING = 1;
    localparam int ERR_BREAK   = 2;

    // System clocks per serial bit (integer divide, remainder dropped)
    function automatic int clks_per_bit(input int sysclk_rate, input int baud_rate);
        return sysclk_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive FIFO with registered status flags.
// Storage, read/write pointers, occupancy count, Empty/Full/Overflow.
// Optional macro UART_RX_RTS_EN: RTS drops when occupancy reaches
// FIFO_DEPTH-1; without it RTS is tied high and no comparator exists.
module uart_rx_fifo
    import UARTPkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic                 Push,
    input  logic [DATA_BITS-1:0] Push_Data,
    input  logic                 Pop,
    output logic [DATA_BITS-1:0] Pop_Data,
    output logic                 Empty,
    output logic                 Full,
    output logic                 Overflow,
    output logic                 RTS
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count, count_nxt;
    logic                 do_push, do_pop, drop;

    // Decide which of push/pop actually take effect this cycle.
    // A pop while full frees a slot, so a simultaneous push still lands.
    always_comb begin
        do_pop    = Pop && (count != '0);
        do_push   = Push && ((count != DEPTH_C) || do_pop);
        drop      = Push && (count == DEPTH_C) && !do_pop;
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    // Storage write; contents need no reset since pointers gate reads.
    always_ff @(posedge SysClk) begin
        if (do_push)
            mem[wr_ptr] <= Push_Data;
    end

    // Pointers, occupancy, registered flags and the popped word.
    always_ff @(posedge SysClk) begin
        if (Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            Pop_Data <= '0;
            Empty    <= 1'b1;
            Full     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                Pop_Data <= mem[rd_ptr];
            end
            count <= count_nxt;
            Empty <= (count_nxt == '0);
            Full  <= (count_nxt == DEPTH_C);
            // Sticky drop indication, released by the next real pop
            if (do_pop)
                Overflow <= 1'b0;
            else if (drop)
                Overflow <= 1'b1;
        end
    end

`ifdef UART_RX_RTS_EN
    localparam logic [CW-1:0] RTS_LIMIT = CW'(FIFO_DEPTH - 1);

    // Flow control: ask the sender to pause one slot before full.
    always_ff @(posedge SysClk) begin
        if (Rst)
            RTS <= 1'b1;
        else
            RTS <= (count_nxt < RTS_LIMIT);
    end
`else
    assign RTS = 1'b1;
`endif

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: asynchronous serial receiver with receive FIFO.
// Rx synchronizer, frame FSM (IDLE/START/DATA/PARITY/STOP) and the
// bit/clock counters live here; buffering is in uart_rx_fifo.
// Optional macro UART_RX_RTS_EN enables occupancy-based RTS.
module uart_receiver
    import UARTPkg::*;
#(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 1,
    parameter int STOP_BITS   = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic                 Read_Done,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic                 Data_Rdy,
    output logic [2:0]           Rx_Error,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 FIFO_Overflow,
    output logic                 RTS
);

    localparam int CPB   = clks_per_bit(SYSCLK_RATE, BAUD_RATE);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BIT_W = $clog2(DATA_BITS) + 1;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    logic                 rx_meta, rx_sync;
    rx_state_t            state, state_nxt;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic                 par_err_q, par_err_nxt;
    logic                 frm_err_q, frm_err_nxt;
    logic                 frame_done, brk;

    // Two-flop synchronizer; reset to the idle line level.
    always_ff @(posedge SysClk) begin
        if (Rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
        end
    end

    // Frame FSM next state, counters and per-frame error accumulation.
    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_q;
        par_err_nxt = par_err_q;
        frm_err_nxt = frm_err_q;
        frame_done  = 1'b0;
        brk         = 1'b0;
        unique case (state)
            IDLE: begin
                clk_cnt_nxt = '0;
                if (!rx_sync) begin
                    state_nxt   = START;
                    bit_cnt_nxt = '0;
                    par_err_nxt = 1'b0;
                    frm_err_nxt = 1'b0;
                end
            end
            START: begin
                // Re-check at mid start bit; a high line here was noise
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == CNT_FULL) begin
                    clk_cnt_nxt = '0;
                    shift_nxt   = {rx_sync, shift_q[DATA_BITS-1:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = (PARITY_BIT != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (clk_cnt == CNT_FULL) begin
                    clk_cnt_nxt = '0;
                    par_err_nxt = (^shift_q) ^ rx_sync;
                    state_nxt   = STOP;
                end
            end
            STOP: begin
                if (clk_cnt == CNT_FULL) begin
                    clk_cnt_nxt = '0;
                    frm_err_nxt = frm_err_q | ~rx_sync;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    // Finish at the last stop centre, not the bit end
                    if (bit_cnt == LAST_STOP) begin
                        state_nxt  = IDLE;
                        frame_done = 1'b1;
                        brk        = (shift_q == '0) && frm_err_nxt;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State/counter registers plus the frame result outputs.
    always_ff @(posedge SysClk) begin
        if (Rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            Data_Rdy  <= 1'b0;
            Rx_Error  <= '0;
        end else begin
            state     <= state_nxt;
            clk_cnt   <= clk_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_q   <= shift_nxt;
            par_err_q <= par_err_nxt;
            frm_err_q <= frm_err_nxt;
            // Break frames report errors but never reach the FIFO
            Data_Rdy  <= frame_done && !brk;
            if (frame_done) begin
                Rx_Error[ERR_PARITY]  <= par_err_q;
                Rx_Error[ERR_FRAMING] <= frm_err_nxt;
                Rx_Error[ERR_BREAK]   <= brk;
            end
        end
    end

    // shift_q is stable through the Data_Rdy cycle, so it feeds the push.
    uart_rx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .SysClk    (SysClk),
        .Rst       (Rst),
        .Push      (Data_Rdy),
        .Push_Data (shift_q),
        .Pop       (Read_Done),
        .Pop_Data  (Data_Out),
        .Empty     (FIFO_Empty),
        .Full      (FIFO_Full),
        .Overflow  (FIFO_Overflow),
        .RTS       (RTS)
    );

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver at 16 clocks/bit.
// Table of frames with expected error/push outcome, then hand-written
// sequences for break, glitch, FIFO fill/overflow and mid-frame reset.
module tb_uart_receiver;

    localparam int CPB = 16;

`ifdef UART_RX_RTS_EN
    localparam bit RTS_EN = 1'b1;
`else
    localparam bit RTS_EN = 1'b0;
`endif

    logic       SysClk = 1'b0;
    logic       Rst, Rx, Read_Done;
    logic [7:0] Data_Out;
    logic       Data_Rdy;
    logic [2:0] Rx_Error;
    logic       FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS;

    int vec_cnt = 0;
    int bad_cnt = 0;
    int rdy_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic [1:0] stop_hi;   // bit i = level driven on stop bit i
        logic [2:0] exp_err;
        logic       exp_push;
    } vec_t;

    vec_t vt[8];

    uart_receiver #(
        .SYSCLK_RATE (1600000),
        .BAUD_RATE   (100000),
        .DATA_BITS   (8),
        .PARITY_BIT  (1),
        .STOP_BITS   (2),
        .FIFO_DEPTH  (8)
    ) dut (
        .SysClk        (SysClk),
        .Rst           (Rst),
        .Rx            (Rx),
        .Read_Done     (Read_Done),
        .Data_Out      (Data_Out),
        .Data_Rdy      (Data_Rdy),
        .Rx_Error      (Rx_Error),
        .FIFO_Empty    (FIFO_Empty),
        .FIFO_Full     (FIFO_Full),
        .FIFO_Overflow (FIFO_Overflow),
        .RTS           (RTS)
    );

    always #5 SysClk = ~SysClk;

    // Count Data_Rdy pulses, sampled away from the active edge
    always @(negedge SysClk) if (Data_Rdy === 1'b1) rdy_cnt++;

    // Hang guard
    initial begin
        #1000000;
        $display("FAIL timeout: run did not finish, expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pf, input logic [1:0] sh);
        Rx = 1'b0;
        repeat (CPB) @(negedge SysClk);
        for (int i = 0; i < 8; i++) begin
            Rx = d[i];
            repeat (CPB) @(negedge SysClk);
        end
        Rx = (^d) ^ pf;
        repeat (CPB) @(negedge SysClk);
        for (int i = 0; i < 2; i++) begin
            Rx = sh[i];
            repeat (CPB) @(negedge SysClk);
        end
        Rx = 1'b1;
        repeat (20) @(negedge SysClk);
    endtask

    task automatic pop(input logic [7:0] exp, input string nm);
        @(negedge SysClk);
        Read_Done = 1'b1;
        @(negedge SysClk);
        Read_Done = 1'b0;
        chk(nm, 32'(Data_Out), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge SysClk);
        Rst = 1'b1;
        Rx  = 1'b1;
        repeat (2) @(negedge SysClk);
        Rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data_out"}, 32'(Data_Out), 0);
        chk({tag, "_data_rdy"}, 32'(Data_Rdy), 0);
        chk({tag, "_rx_error"}, 32'(Rx_Error), 0);
        chk({tag, "_empty"}, 32'(FIFO_Empty), 1);
        chk({tag, "_full"}, 32'(FIFO_Full), 0);
        chk({tag, "_overflow"}, 32'(FIFO_Overflow), 0);
        chk({tag, "_rts"}, 32'(RTS), 1);
    endtask

    initial begin
        int   r0;
        logic seen;
        logic [7:0] exp_q [$];

        // data, parity flip, stop levels, expected Rx_Error, pushed
        vt[0] = '{8'hA5, 1'b0, 2'b11, 3'b000, 1'b1};
        vt[1] = '{8'h3C, 1'b1, 2'b11, 3'b001, 1'b1};
        vt[2] = '{8'h55, 1'b0, 2'b10, 3'b010, 1'b1};
        vt[3] = '{8'h00, 1'b0, 2'b11, 3'b000, 1'b1};
        vt[4] = '{8'hFF, 1'b1, 2'b11, 3'b001, 1'b1};
        vt[5] = '{8'h81, 1'b0, 2'b01, 3'b010, 1'b1};
        vt[6] = '{8'h00, 1'b0, 2'b10, 3'b110, 1'b0};
        vt[7] = '{8'h0F, 1'b1, 2'b10, 3'b011, 1'b1};

        Rst = 1'b1; Rx = 1'b1; Read_Done = 1'b0;
        repeat (3) @(negedge SysClk);
        Rst = 1'b0;
        chk_reset_vals("reset");
        repeat (5) @(negedge SysClk);

        // Table-driven frames
        for (int v = 0; v < 8; v++) begin
            r0 = rdy_cnt;
            send_frame(vt[v].data, vt[v].par_flip, vt[v].stop_hi);
            chk($sformatf("v%0d_pushes", v), 32'(rdy_cnt - r0), 32'(vt[v].exp_push));
            chk($sformatf("v%0d_rx_error", v), 32'(Rx_Error), 32'(vt[v].exp_err));
            chk($sformatf("v%0d_empty_before_pop", v), 32'(FIFO_Empty), 32'(!vt[v].exp_push));
            if (vt[v].exp_push) begin
                pop(vt[v].data, $sformatf("v%0d_data_out", v));
                chk($sformatf("v%0d_empty_after_pop", v), 32'(FIFO_Empty), 1);
            end
        end

        // Long break: one frame of zeros with low stops, never pushed.
        // The line is still low when the FSM returns to IDLE, so a second
        // frame starts; reset clears it before it can complete.
        r0 = rdy_cnt;
        Rx = 1'b0;
        repeat (240) @(negedge SysClk);
        Rx = 1'b1;
        repeat (5) @(negedge SysClk);
        chk("break_no_push", 32'(rdy_cnt - r0), 0);
        chk("break_rx_error", 32'(Rx_Error), 32'b110);
        chk("break_empty", 32'(FIFO_Empty), 1);
        do_reset();

        // Short glitch rejected at the start-bit midpoint
        r0 = rdy_cnt;
        Rx = 1'b0;
        repeat (4) @(negedge SysClk);
        Rx = 1'b1;
        repeat (220) @(negedge SysClk);
        chk("glitch_no_push", 32'(rdy_cnt - r0), 0);
        chk("glitch_rx_error", 32'(Rx_Error), 0);

        // Fill past capacity: 0x01..0x09 with no pops
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b0, 2'b11);
            chk($sformatf("fill%0d_full", i), 32'(FIFO_Full), 32'(i >= 8));
            chk($sformatf("fill%0d_overflow", i), 32'(FIFO_Overflow), 32'(i == 9));
            chk($sformatf("fill%0d_rts", i), 32'(RTS), 32'(!(RTS_EN && i >= 7)));
        end
        pop(8'h01, "ovf_pop1");
        chk("ovf_cleared", 32'(FIFO_Overflow), 0);
        chk("full_after_pop", 32'(FIFO_Full), 0);
        send_frame(8'h0A, 1'b0, 2'b11);
        chk("refill_full", 32'(FIFO_Full), 1);

        // Push and pop on the same edge while full
        seen = 1'b0;
        fork
            send_frame(8'h0B, 1'b0, 2'b11);
            begin
                for (int k = 0; k < 400 && !seen; k++) begin
                    @(negedge SysClk);
                    if (Data_Rdy === 1'b1) seen = 1'b1;
                end
                if (seen) begin
                    Read_Done = 1'b1;
                    @(negedge SysClk);
                    Read_Done = 1'b0;
                end
            end
        join
        chk("simul_seen_rdy", 32'(seen), 1);
        chk("simul_data_out", 32'(Data_Out), 32'h02);
        chk("simul_full", 32'(FIFO_Full), 1);
        chk("simul_overflow", 32'(FIFO_Overflow), 0);
        exp_q = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h0B};
        foreach (exp_q[i]) pop(exp_q[i], $sformatf("drain%0d", i));
        chk("drain_empty", 32'(FIFO_Empty), 1);

        // Pop while empty leaves Data_Out alone
        pop(8'h0B, "pop_empty_hold");
        chk("pop_empty_still_empty", 32'(FIFO_Empty), 1);

        // Reset mid-DATA with a queued word and a latched error
        send_frame(8'h3C, 1'b1, 2'b11);
        chk("pre_rst_err", 32'(Rx_Error), 1);
        Rx = 1'b0;
        repeat (CPB) @(negedge SysClk);
        for (int i = 0; i < 3; i++) begin
            Rx = ~i[0];
            repeat (CPB) @(negedge SysClk);
        end
        do_reset();
        chk_reset_vals("midrst");
        repeat (5) @(negedge SysClk);
        r0 = rdy_cnt;
        send_frame(8'h7E, 1'b0, 2'b11);
        chk("post_rst_push", 32'(rdy_cnt - r0), 1);
        chk("post_rst_err", 32'(Rx_Error), 0);
        pop(8'h7E, "post_rst_data");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, bad_cnt);
        $finish;
    end

endmodule
